pov_anim_player: RTL



---
 rtl/pov_anim_player.sv | 110 +++++++++++
 1 files changed

// File: rtl/pov_anim_player.sv
// pov_anim_player: LED-fan angle tracker driving LEDs from a multi-frame pattern RAM.
// Angle steps on fanclk and resyncs on sync. The frame advances every REVS_PER_FRAME revolutions.
module pov_anim_player #(
  parameter int NUM_LED        = 16,
  parameter int STEPS          = 360,
  parameter int FRAMES         = 4,
  parameter int REVS_PER_FRAME = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fanclk,
  input  logic                         sync,
  input  logic                         enable,
  input  logic                         wr_en,
  input  logic [$clog2(FRAMES)-1:0]    wr_frame,
  input  logic [$clog2(STEPS+1)-1:0]   wr_step,
  input  logic [NUM_LED-1:0]           wr_data,
  output logic [NUM_LED-1:0]           led,
  output logic [$clog2(STEPS+1)-1:0]   deg,
  output logic [$clog2(FRAMES)-1:0]    frame,
  output logic                         sync_err
);
  localparam int DW    = $clog2(STEPS+1);
  localparam int FW    = $clog2(FRAMES);
  localparam int DEPTH = FRAMES*STEPS;
  localparam int AW    = $clog2(DEPTH);
  localparam int XW    = AW+DW+1;  // holds frame*STEPS + step without overflow
  localparam int RW    = (REVS_PER_FRAME > 1) ? $clog2(REVS_PER_FRAME) : 1;

  logic                fanclk_q, sync_q;
  logic                fan_edge, sync_edge, rev_done;
  logic [DW-1:0]       deg_q, deg_d;
  logic [FW-1:0]       frame_q, frame_d;
  logic [RW-1:0]       rev_q, rev_d;
  logic                sync_err_q, sync_err_d;
  logic [NUM_LED-1:0]  led_q;
  logic [NUM_LED-1:0]  mem [DEPTH];
  logic [XW-1:0]       wr_ax;
  logic [AW-1:0]       rd_addr;
  logic                wr_ok;

  always_comb begin
    fan_edge  = fanclk & ~fanclk_q;
    sync_edge = sync & ~sync_q;
    deg_d     = deg_q;
    rev_done  = 1'b0;
    // sync wins over a coincident fan step and counts as one revolution
    if (sync_edge) begin
      deg_d    = DW'(STEPS);
      rev_done = 1'b1;
    end else if (fan_edge) begin
      if (deg_q == DW'(1)) begin
        deg_d    = DW'(STEPS);
        rev_done = 1'b1;
      end else begin
        deg_d = deg_q - DW'(1);
      end
    end
    sync_err_d = sync_edge & (deg_q != DW'(1));
    rev_d      = rev_q;
    frame_d    = frame_q;
    if (rev_done) begin
      if (rev_q == RW'(REVS_PER_FRAME-1)) begin
        rev_d   = '0;
        frame_d = (frame_q == FW'(FRAMES-1)) ? '0 : frame_q + FW'(1);
      end else begin
        rev_d = rev_q + RW'(1);
      end
    end
  end

  always_comb begin
    rd_addr = AW'(XW'(frame_q) * XW'(STEPS) + XW'(deg_q) - XW'(1));
    wr_ax   = XW'(wr_frame) * XW'(STEPS) + XW'(wr_step) - XW'(1);
    wr_ok   = wr_en && (wr_step != '0) && (XW'(wr_step) <= XW'(STEPS)) && (wr_ax < XW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fanclk_q   <= 1'b1;
      sync_q     <= 1'b1;
      deg_q      <= DW'(STEPS);
      frame_q    <= '0;
      rev_q      <= '0;
      sync_err_q <= 1'b0;
    end else begin
      fanclk_q   <= fanclk;
      sync_q     <= sync;
      deg_q      <= deg_d;
      frame_q    <= frame_d;
      rev_q      <= rev_d;
      sync_err_q <= sync_err_d;
    end
  end

  // Pattern RAM: read-first, the read register is the LED output itself
  always_ff @(posedge clk) begin
    if (wr_ok) mem[AW'(wr_ax)] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) led_q <= '0;
    else     led_q <= enable ? mem[rd_addr] : '0;
  end

  assign led      = led_q;
  assign deg      = deg_q;
  assign frame    = frame_q;
  assign sync_err = sync_err_q;
endmodule
